// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: op encoding, byte-lane constants.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package mem_stage_pkg;

  typedef enum logic [2:0] {
    MEM_NONE = 3'd0,
    MEM_LW   = 3'd1,
    MEM_LBU  = 3'd2,
    MEM_SW   = 3'd3,
    MEM_SB   = 3'd4
  } mem_op_e;

  localparam int          LANES              = 4;
  localparam int          BYTE_W             = 8;
  localparam logic [3:0]  MASK_NONE          = 4'b0000;
  localparam logic [3:0]  MASK_WORD          = 4'b1111;
  localparam logic [3:0]  MASK_LANE0         = 4'b0001;
  localparam int          TIMEOUT_CYCLES_DEF = 256;

  // True for ops that go out to data memory.
  function automatic logic is_mem(input mem_op_e op);
    return (op == MEM_LW) || (op == MEM_LBU) || (op == MEM_SW) || (op == MEM_SB);
  endfunction

  // True for ops that write memory.
  function automatic logic is_store(input mem_op_e op);
    return (op == MEM_SW) || (op == MEM_SB);
  endfunction

  // True for full-word accesses, which must be 4-byte aligned.
  function automatic logic is_word(input mem_op_e op);
    return (op == MEM_LW) || (op == MEM_SW);
  endfunction

endpackage

// File: rtl/mem_stage_byte_lane_unit.sv
// Byte-lane steering: store mask/data generation and load byte extraction.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
module byte_lane_unit
  import mem_stage_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] sdata_i,
  input  logic [31:0] rsp_i,
  output logic [3:0]  wmask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  mem_op_e     op;
  logic [7:0]  rsp_byte;

  assign op = mem_op_e'(op_i);

  // Select the addressed byte of the response word; lane 0 is bits [7:0].
  always_comb begin
    rsp_byte = rsp_i[7:0];
    case (off_i)
      2'd1:    rsp_byte = rsp_i[15:8];
      2'd2:    rsp_byte = rsp_i[23:16];
      2'd3:    rsp_byte = rsp_i[31:24];
      default: rsp_byte = rsp_i[7:0];
    endcase
  end

  // Build write mask/data for stores and the writeback value for loads.
  always_comb begin
    wmask_o = MASK_NONE;
    wdata_o = '0;
    rdata_o = rsp_i;
    case (op)
      MEM_SW: begin
        wmask_o = MASK_WORD;
        wdata_o = sdata_i;
      end
      MEM_SB: begin
        wmask_o = MASK_LANE0 << off_i;
        wdata_o = {LANES{sdata_i[BYTE_W-1:0]}};
      end
      MEM_LBU: rdata_o = {24'b0, rsp_byte};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: registers ALU results, runs LW/LBU/SW/SB through dmem, one writeback beat each.
// Latency: ALU op 1 cycle; store 2 + req stall; load 2 + req stall + rsp delay + 1.
// Backpressure: ex_ready_o low outside IDLE; request held stable until dmem_req_ready_i.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int DATA_W         = 32
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [DATA_W-1:0] ex_result_i,
  input  logic [DATA_W-1:0] ex_store_data_i,
  input  logic [2:0]        ex_mem_op_i,
  input  logic [4:0]        ex_rd_addr_i,
  input  logic              ex_wen_i,
  output logic              dmem_req_v_o,
  input  logic              dmem_req_ready_i,
  output logic [DATA_W-1:0] dmem_addr_o,
  output logic              dmem_we_o,
  output logic [3:0]        dmem_wmask_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_rsp_v_i,
  input  logic [DATA_W-1:0] dmem_rsp_data_i,
  output logic              wb_valid_o,
  output logic              wb_wen_o,
  output logic [4:0]        wb_rd_addr_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              misalign_o,
  output logic              timeout_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] sdata_q, sdata_d;
  mem_op_e           op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic              wen_q, wen_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wb_valid_q, wb_valid_d;
  logic              wb_wen_q, wb_wen_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              misalign_q, misalign_d;
  logic              timeout_q, timeout_d;

  mem_op_e           ex_op;
  logic              accept;
  logic              req_act;
  logic [3:0]        lane_wmask;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] lane_rdata;

  assign ex_op      = mem_op_e'(ex_mem_op_i);
  assign ex_ready_o = (state_q == ST_IDLE);
  assign accept     = ex_valid_i & ex_ready_o;
  assign req_act    = (state_q == ST_REQ);

  byte_lane_unit u_lanes (
    .op_i    (op_q),
    .off_i   (addr_q[1:0]),
    .sdata_i (sdata_q),
    .rsp_i   (dmem_rsp_data_i),
    .wmask_o (lane_wmask),
    .wdata_o (lane_wdata),
    .rdata_o (lane_rdata)
  );

  // Request fields come straight from the latched instruction, so they stay stable through a stall.
  assign dmem_req_v_o = req_act;
  assign dmem_addr_o  = req_act ? {addr_q[DATA_W-1:2], 2'b00} : '0;
  assign dmem_we_o    = req_act & is_store(op_q);
  assign dmem_wmask_o = req_act ? lane_wmask : MASK_NONE;
  assign dmem_wdata_o = req_act ? lane_wdata : '0;

  assign wb_valid_o   = wb_valid_q;
  assign wb_wen_o     = wb_wen_q;
  assign wb_rd_addr_o = wb_rd_q;
  assign wb_data_o    = wb_data_q;
  assign misalign_o   = misalign_q;
  assign timeout_o    = timeout_q;

  // FSM next state, instruction latch, timeout counter and single-cycle output pulses.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    sdata_d    = sdata_q;
    op_d       = op_q;
    rd_d       = rd_q;
    wen_d      = wen_q;
    cnt_d      = cnt_q;
    wb_valid_d = 1'b0;
    wb_wen_d   = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    misalign_d = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!is_mem(ex_op)) begin
            wb_valid_d = 1'b1;
            wb_wen_d   = ex_wen_i;
            wb_rd_d    = ex_rd_addr_i;
            wb_data_d  = ex_result_i;
          end else if (is_word(ex_op) && (ex_result_i[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
          end else begin
            addr_d  = ex_result_i;
            sdata_d = ex_store_data_i;
            op_d    = ex_op;
            rd_d    = ex_rd_addr_i;
            wen_d   = ex_wen_i;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (dmem_req_ready_i) begin
          if (is_store(op_q)) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            state_d    = ST_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // A response in the last counted cycle still wins over the timeout.
        if (dmem_rsp_v_i) begin
          wb_valid_d = 1'b1;
          wb_wen_d   = wen_q;
          wb_rd_d    = rd_q;
          wb_data_d  = lane_rdata;
          state_d    = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops any outstanding access and pending beat.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      sdata_q    <= '0;
      op_q       <= MEM_NONE;
      rd_q       <= '0;
      wen_q      <= 1'b0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_wen_q   <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      sdata_q    <= sdata_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      wen_q      <= wen_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_wen_q   <= wb_wen_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table for single-cycle ops plus memory-access sequences.
// Latency: stepped one clock at a time, outputs sampled 1ns after the rising edge.
// Backpressure: dmem ready/response driven explicitly per cycle.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [31:0] ex_result_i;
  logic [31:0] ex_store_data_i;
  logic [2:0]  ex_mem_op_i;
  logic [4:0]  ex_rd_addr_i;
  logic        ex_wen_i;
  logic        dmem_req_v_o;
  logic        dmem_req_ready_i;
  logic [31:0] dmem_addr_o;
  logic        dmem_we_o;
  logic [3:0]  dmem_wmask_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_rsp_v_i;
  logic [31:0] dmem_rsp_data_i;
  logic        wb_valid_o;
  logic        wb_wen_o;
  logic [4:0]  wb_rd_addr_o;
  logic [31:0] wb_data_o;
  logic        misalign_o;
  logic        timeout_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(8), .DATA_W(32)) dut (
    .clk             (clk),
    .n_reset         (n_reset),
    .ex_valid_i      (ex_valid_i),
    .ex_ready_o      (ex_ready_o),
    .ex_result_i     (ex_result_i),
    .ex_store_data_i (ex_store_data_i),
    .ex_mem_op_i     (ex_mem_op_i),
    .ex_rd_addr_i    (ex_rd_addr_i),
    .ex_wen_i        (ex_wen_i),
    .dmem_req_v_o    (dmem_req_v_o),
    .dmem_req_ready_i(dmem_req_ready_i),
    .dmem_addr_o     (dmem_addr_o),
    .dmem_we_o       (dmem_we_o),
    .dmem_wmask_o    (dmem_wmask_o),
    .dmem_wdata_o    (dmem_wdata_o),
    .dmem_rsp_v_i    (dmem_rsp_v_i),
    .dmem_rsp_data_i (dmem_rsp_data_i),
    .wb_valid_o      (wb_valid_o),
    .wb_wen_o        (wb_wen_o),
    .wb_rd_addr_o    (wb_rd_addr_o),
    .wb_data_o       (wb_data_o),
    .misalign_o      (misalign_o),
    .timeout_o       (timeout_o)
  );

  typedef struct {
    logic        vld;
    logic [31:0] res;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic        wen;
    logic        e_wbv;
    logic [31:0] e_data;
    logic [4:0]  e_rd;
    logic        e_wen;
    logic        e_mis;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] res, input logic [31:0] sd,
                       input logic [4:0] rd, input logic wen);
    ex_valid_i      = 1'b1;
    ex_mem_op_i     = op;
    ex_result_i     = res;
    ex_store_data_i = sd;
    ex_rd_addr_i    = rd;
    ex_wen_i        = wen;
  endtask

  task automatic idle_ex();
    ex_valid_i  = 1'b0;
    ex_mem_op_i = MEM_NONE;
  endtask

  initial begin
    n_reset = 1'b0;
    ex_valid_i = 1'b0; ex_result_i = '0; ex_store_data_i = '0; ex_mem_op_i = MEM_NONE;
    ex_rd_addr_i = '0; ex_wen_i = 1'b0; dmem_req_ready_i = 1'b0; dmem_rsp_v_i = 1'b0;
    dmem_rsp_data_i = '0;

    //             vld   res            op        rd   wen  e_wbv e_data        e_rd e_wen e_mis
    tbl[0] = '{1'b1, 32'h0000_0011, MEM_NONE, 5'd1,  1'b1, 1'b1, 32'h0000_0011, 5'd1,  1'b1, 1'b0};
    tbl[1] = '{1'b1, 32'h0000_0022, MEM_NONE, 5'd2,  1'b1, 1'b1, 32'h0000_0022, 5'd2,  1'b1, 1'b0};
    tbl[2] = '{1'b1, 32'h0000_0033, MEM_NONE, 5'd3,  1'b1, 1'b1, 32'h0000_0033, 5'd3,  1'b1, 1'b0};
    tbl[3] = '{1'b1, 32'h0000_0006, MEM_LW,   5'd4,  1'b1, 1'b0, 32'h0,         5'd0,  1'b0, 1'b1};
    tbl[4] = '{1'b1, 32'hFFFF_FFFF, MEM_NONE, 5'd31, 1'b0, 1'b1, 32'hFFFF_FFFF, 5'd31, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 32'h0000_3001, MEM_SW,   5'd6,  1'b0, 1'b0, 32'h0,         5'd0,  1'b0, 1'b1};
    tbl[6] = '{1'b0, 32'h0000_0077, MEM_NONE, 5'd7,  1'b1, 1'b0, 32'h0,         5'd0,  1'b0, 1'b0};
    tbl[7] = '{1'b1, 32'h8000_0000, MEM_NONE, 5'd8,  1'b1, 1'b1, 32'h8000_0000, 5'd8,  1'b1, 1'b0};

    // Reset state
    #1;
    chk("rst_ready", ex_ready_o, 1);
    chk("rst_req_v", dmem_req_v_o, 0);
    chk("rst_wbv", wb_valid_o, 0);
    chk("rst_mis", misalign_o, 0);
    chk("rst_to", timeout_o, 0);
    chk("rst_wbdata", wb_data_o, 0);
    step(); step();
    n_reset = 1'b1;
    step();

    // Single-cycle ops back to back
    for (int i = 0; i < 8; i++) begin
      chk("tbl_ready", ex_ready_o, 1);
      ex_valid_i = tbl[i].vld; ex_result_i = tbl[i].res; ex_mem_op_i = tbl[i].op;
      ex_rd_addr_i = tbl[i].rd; ex_wen_i = tbl[i].wen; ex_store_data_i = 32'h5A5A_5A5A;
      step();
      chk("tbl_wbv", wb_valid_o, tbl[i].e_wbv);
      chk("tbl_mis", misalign_o, tbl[i].e_mis);
      chk("tbl_req_v", dmem_req_v_o, 0);
      if (tbl[i].e_wbv) begin
        chk("tbl_data", wb_data_o, tbl[i].e_data);
        chk("tbl_rd", wb_rd_addr_o, tbl[i].e_rd);
        chk("tbl_wen", wb_wen_o, tbl[i].e_wen);
      end
    end
    idle_ex();
    step();

    // LBU 0x1002, spurious response in handshake cycle, real response 2 cycles later
    issue(MEM_LBU, 32'h0000_1002, 32'h0, 5'd5, 1'b1);
    step();
    idle_ex();
    chk("lbu_ready0", ex_ready_o, 0);
    chk("lbu_req_v", dmem_req_v_o, 1);
    chk("lbu_addr", dmem_addr_o, 32'h0000_1000);
    chk("lbu_we", dmem_we_o, 0);
    chk("lbu_wmask", dmem_wmask_o, 0);
    dmem_req_ready_i = 1'b1;
    dmem_rsp_v_i = 1'b1; dmem_rsp_data_i = 32'h1111_1111;
    step();
    dmem_req_ready_i = 1'b0; dmem_rsp_v_i = 1'b0;
    chk("lbu_hs_wbv", wb_valid_o, 0);
    chk("lbu_hs_ready", ex_ready_o, 0);
    chk("lbu_hs_req_v", dmem_req_v_o, 0);
    step();
    chk("lbu_w1_wbv", wb_valid_o, 0);
    chk("lbu_w1_ready", ex_ready_o, 0);
    dmem_rsp_v_i = 1'b1; dmem_rsp_data_i = 32'hAABB_CCDD;
    step();
    dmem_rsp_v_i = 1'b0;
    chk("lbu_wbv", wb_valid_o, 1);
    chk("lbu_data", wb_data_o, 32'h0000_00BB);
    chk("lbu_wen", wb_wen_o, 1);
    chk("lbu_rd", wb_rd_addr_o, 5);
    chk("lbu_ready1", ex_ready_o, 1);
    step();
    chk("lbu_wbv_once", wb_valid_o, 0);

    // SB 0x2003 with 3 stall cycles
    issue(MEM_SB, 32'h0000_2003, 32'h1234_56EF, 5'd9, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      idle_ex();
      chk("sb_req_v", dmem_req_v_o, 1);
      chk("sb_addr", dmem_addr_o, 32'h0000_2000);
      chk("sb_we", dmem_we_o, 1);
      chk("sb_wmask", dmem_wmask_o, 4'b1000);
      chk("sb_wdata", dmem_wdata_o, 32'hEFEF_EFEF);
      chk("sb_ready", ex_ready_o, 0);
      dmem_req_ready_i = (i == 3);
    end
    step();
    dmem_req_ready_i = 1'b0;
    chk("sb_wbv", wb_valid_o, 1);
    chk("sb_wen", wb_wen_o, 0);
    chk("sb_req_v_off", dmem_req_v_o, 0);
    chk("sb_ready1", ex_ready_o, 1);

    // SW aligned, immediate handshake
    issue(MEM_SW, 32'h0000_3000, 32'hCAFE_F00D, 5'd10, 1'b0);
    step();
    idle_ex();
    chk("sw_wmask", dmem_wmask_o, 4'b1111);
    chk("sw_wdata", dmem_wdata_o, 32'hCAFE_F00D);
    chk("sw_we", dmem_we_o, 1);
    dmem_req_ready_i = 1'b1;
    step();
    dmem_req_ready_i = 1'b0;
    chk("sw_wbv", wb_valid_o, 1);
    chk("sw_wen", wb_wen_o, 0);

    // LW with no response: timeout 8 edges after handshake, late response ignored
    issue(MEM_LW, 32'h0000_0004, 32'h0, 5'd7, 1'b1);
    step();
    idle_ex();
    dmem_req_ready_i = 1'b1;
    step();
    dmem_req_ready_i = 1'b0;
    for (int k = 1; k < 8; k++) begin
      step();
      chk("to_pending", timeout_o, 0);
      chk("to_ready0", ex_ready_o, 0);
    end
    step();
    chk("to_pulse", timeout_o, 1);
    chk("to_wbv", wb_valid_o, 0);
    chk("to_ready1", ex_ready_o, 1);
    step();
    chk("to_clear", timeout_o, 0);
    dmem_rsp_v_i = 1'b1; dmem_rsp_data_i = 32'hDEAD_BEEF;
    step();
    dmem_rsp_v_i = 1'b0;
    chk("late_rsp_wbv", wb_valid_o, 0);
    chk("late_rsp_ready", ex_ready_o, 1);
    issue(MEM_NONE, 32'h0000_0055, 32'h0, 5'd9, 1'b1);
    step();
    idle_ex();
    chk("after_to_wbv", wb_valid_o, 1);
    chk("after_to_data", wb_data_o, 32'h0000_0055);

    // LW whose response lands in the last counted cycle: response wins
    issue(MEM_LW, 32'h0000_0010, 32'h0, 5'd12, 1'b1);
    step();
    idle_ex();
    dmem_req_ready_i = 1'b1;
    step();
    dmem_req_ready_i = 1'b0;
    for (int k = 1; k < 8; k++) step();
    dmem_rsp_v_i = 1'b1; dmem_rsp_data_i = 32'h0102_0304;
    step();
    dmem_rsp_v_i = 1'b0;
    chk("race_wbv", wb_valid_o, 1);
    chk("race_to", timeout_o, 0);
    chk("race_data", wb_data_o, 32'h0102_0304);
    chk("race_rd", wb_rd_addr_o, 12);

    // Reset while in WAIT_RSP, then a stray response
    issue(MEM_LW, 32'h0000_0008, 32'h0, 5'd3, 1'b1);
    step();
    idle_ex();
    dmem_req_ready_i = 1'b1;
    step();
    dmem_req_ready_i = 1'b0;
    step();
    n_reset = 1'b0;
    #1;
    chk("mid_rst_ready", ex_ready_o, 1);
    chk("mid_rst_req_v", dmem_req_v_o, 0);
    chk("mid_rst_wbv", wb_valid_o, 0);
    chk("mid_rst_wbdata", wb_data_o, 0);
    chk("mid_rst_to", timeout_o, 0);
    step(); step();
    n_reset = 1'b1;
    dmem_rsp_v_i = 1'b1; dmem_rsp_data_i = 32'h7777_7777;
    step();
    dmem_rsp_v_i = 1'b0;
    chk("post_rst_wbv", wb_valid_o, 0);
    chk("post_rst_ready", ex_ready_o, 1);
    chk("post_rst_req_v", dmem_req_v_o, 0);
    step();
    chk("post_rst_wbv2", wb_valid_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
